// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, fixed-latency ROM fetch and instruction register for the ControlUnit
//
// Fetches 16-bit instructions from a synchronous ROM with IM_LAT cycles of read
// latency and presents them in IR, handshaking with Instr_Valid/Instr_Ready.
// Jump loads an absolute fetch address. Fetching stops for good once a HALT
// opcode has been consumed; only reset leaves that state.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-low reset
//   IM_Addr      out  ROM read address (the fetch PC)
//   IM_Rd        out  ROM read strobe, one cycle per fetch
//   IM_Data      in   ROM read data, valid IM_LAT cycles after the IM_Rd cycle
//   Instr_Valid  out  IR holds an instruction for the ControlUnit
//   Instr_Ready  in   ControlUnit accepts IR this cycle
//   IR           out  instruction register
//   PC           out  address of the instruction in IR
//   Jump         in   load Jump_Addr as the next fetch address
//   Jump_Addr    in   absolute jump target
//   Halted       out  HALT consumed, fetch stopped

module instr_fetch_unit #(
    parameter int          AW      = 7,
    parameter int          IM_LAT  = 1,
    parameter logic [3:0]  HALT_OP = 4'h5
) (
    input  logic          Clock,
    input  logic          Reset,
    output logic [AW-1:0] IM_Addr,
    output logic          IM_Rd,
    input  logic [15:0]   IM_Data,
    output logic          Instr_Valid,
    input  logic          Instr_Ready,
    output logic [15:0]   IR,
    output logic [AW-1:0] PC,
    input  logic          Jump,
    input  logic [AW-1:0] Jump_Addr,
    output logic          Halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    localparam logic [2:0]    LAT     = 3'(IM_LAT);
    localparam logic [AW-1:0] PC_STEP = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] fetch_pc;
    logic [2:0]    wait_cnt;
    logic          valid_q;
    logic          halted_q;

    logic          handshake;
    logic          halt_taken;
    logic          jump_taken;
    logic          capture;

    // IR is only presented in HOLD, so the handshake can be decoded from state.
    assign handshake  = (state == S_HOLD) && Instr_Ready;
    assign halt_taken = handshake && (IR[15:12] == HALT_OP);
    // Jump overrides everything except HALT and the HALT handshake itself.
    assign jump_taken = Jump && (state != S_HALT) && !halt_taken;
    // A jump in the capture cycle drops the returning ROM word.
    assign capture    = (state == S_WAIT) && (wait_cnt == 3'd1) && !jump_taken;

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: next_state = S_REQ;
            S_REQ:  next_state = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == 3'd1) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (halt_taken) begin
                    next_state = S_HALT;
                end else if (handshake) begin
                    next_state = S_REQ;
                end
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
        if (jump_taken) begin
            next_state = S_REQ;
        end
    end

    // Outputs: the address and the valid/halted flags come straight from flops.
    always_comb begin
        IM_Rd       = (state == S_REQ);
        IM_Addr     = fetch_pc;
        Instr_Valid = valid_q;
        Halted      = halted_q;
    end

    // Datapath: fetch PC, latency counter, IR/PC capture, registered flags
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fetch_pc <= '0;
            wait_cnt <= 3'd0;
            IR       <= 16'h0000;
            PC       <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= (next_state == S_HOLD);
            halted_q <= (next_state == S_HALT);

            if (state == S_REQ) begin
                wait_cnt <= LAT;
            end else if ((state == S_WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (jump_taken) begin
                fetch_pc <= Jump_Addr;
            end else if (capture) begin
                IR       <= IM_Data;
                PC       <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit at ROM latencies 1 and 3

module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        rd    [2];
    logic        valid [2];
    logic        ready [2];
    logic        jump  [2];
    logic        halted[2];
    logic [6:0]  addr  [2];
    logic [6:0]  jaddr [2];
    logic [6:0]  pcv   [2];
    logic [15:0] data  [2];
    logic [15:0] ir    [2];

    logic [15:0] rom [128];
    logic [15:0] p0;
    logic [15:0] p1 [3];

    logic [22:0] q0 [$];
    logic [22:0] q1 [$];
    logic [22:0] e0;
    logic [22:0] e1;

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch_unit #(.AW(7), .IM_LAT(1), .HALT_OP(4'h5)) dut0 (
        .Clock(clk), .Reset(rst_n[0]), .IM_Addr(addr[0]), .IM_Rd(rd[0]),
        .IM_Data(data[0]), .Instr_Valid(valid[0]), .Instr_Ready(ready[0]),
        .IR(ir[0]), .PC(pcv[0]), .Jump(jump[0]), .Jump_Addr(jaddr[0]),
        .Halted(halted[0])
    );

    instr_fetch_unit #(.AW(7), .IM_LAT(3), .HALT_OP(4'h5)) dut1 (
        .Clock(clk), .Reset(rst_n[1]), .IM_Addr(addr[1]), .IM_Rd(rd[1]),
        .IM_Data(data[1]), .Instr_Valid(valid[1]), .Instr_Ready(ready[1]),
        .IR(ir[1]), .PC(pcv[1]), .Jump(jump[1]), .Jump_Addr(jaddr[1]),
        .Halted(halted[1])
    );

    // ROM models: junk on the bus whenever no read was issued
    always @(posedge clk) begin
        p0    <= rd[0] ? rom[addr[0]] : 16'hBAD0;
        p1[0] <= rd[1] ? rom[addr[1]] : 16'hBAD1;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign data[0] = p0;
    assign data[1] = p1[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards: compare on every handshake
    always @(negedge clk) begin
        if (rst_n[0] && valid[0] && ready[0]) begin
            check("sb0_pending", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                check("sb0_pc", 32'(pcv[0]), 32'(e0[22:16]));
                check("sb0_ir", 32'(ir[0]), 32'(e0[15:0]));
            end
        end
        if (rst_n[1] && valid[1] && ready[1]) begin
            check("sb1_pending", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("sb1_pc", 32'(pcv[1]), 32'(e1[22:16]));
                check("sb1_ir", 32'(ir[1]), 32'(e1[15:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int s, output int n);
        n = 0;
        while (valid[s] !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        check("wait_valid", 32'(valid[s]), 1);
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (q0.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        check("drain0", q0.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 128; i++) rom[i] = 16'h1000 | 16'(i);
        rom[0]     = 16'h2010;
        rom[1]     = 16'h3120;
        rom[2]     = 16'h1230;
        rom[3]     = 16'h5000;
        rom[7'h20] = 16'h7777;
        rom[7'h40] = 16'h4ABC;
        rom[7'h7F] = 16'h2001;
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0;
            ready[s] = 1'b0;
            jump[s]  = 1'b0;
            jaddr[s] = 7'h00;
        end
        tick(2);

        check("rst_valid",  32'(valid[0]),  0);
        check("rst_rd",     32'(rd[0]),     0);
        check("rst_addr",   32'(addr[0]),   0);
        check("rst_ir",     32'(ir[0]),     0);
        check("rst_pc",     32'(pcv[0]),    0);
        check("rst_halted", 32'(halted[0]), 0);

        // Ready tied high: 0,1,2 then HALT at 3; a later jump is ignored
        ready[0] = 1'b1;
        q0.push_back({7'h00, 16'h2010});
        q0.push_back({7'h01, 16'h3120});
        q0.push_back({7'h02, 16'h1230});
        q0.push_back({7'h03, 16'h5000});
        rst_n[0] = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            tick(1);
            check($sformatf("a_valid@%0d", t),  32'(valid[0]),  32'(t == 3 || t == 6 || t == 9 || t == 12));
            check($sformatf("a_rd@%0d", t),     32'(rd[0]),     32'(t == 1 || t == 4 || t == 7 || t == 10));
            check($sformatf("a_halted@%0d", t), 32'(halted[0]), 32'(t >= 13));
            if (t == 4) check("a_addr_next", 32'(addr[0]), 1);
            if (t == 15) begin
                jump[0]  = 1'b1;
                jaddr[0] = 7'h20;
            end
            if (t == 16) jump[0] = 1'b0;
        end
        check("a_drain", q0.size(), 0);

        // Backpressure, then a jump during WAIT to the top of the address space
        ready[0] = 1'b0;
        rst_n[0] = 1'b0;
        tick(1);
        check("b_rst_halted", 32'(halted[0]), 0);
        rst_n[0] = 1'b1;
        q0.push_back({7'h00, 16'h2010});
        wait_valid(0, n);
        check("b_first_valid_cycle", n, 3);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("b_hold_ir",    32'(ir[0]),    32'h2010);
            check("b_hold_pc",    32'(pcv[0]),   0);
            check("b_hold_rd",    32'(rd[0]),    0);
            check("b_hold_valid", 32'(valid[0]), 1);
        end
        ready[0] = 1'b1;
        tick(1);
        ready[0] = 1'b0;
        check("b_rd_after_accept",   32'(rd[0]),    1);
        check("b_addr_after_accept", 32'(addr[0]),  1);
        check("b_valid_drop",        32'(valid[0]), 0);
        tick(1);
        rom[0]   = 16'h3000;
        jump[0]  = 1'b1;
        jaddr[0] = 7'h7F;
        tick(1);
        jump[0] = 1'b0;
        check("j_valid",   32'(valid[0]), 0);
        check("j_rd",      32'(rd[0]),    1);
        check("j_addr",    32'(addr[0]),  32'h7F);
        check("j_pc_kept", 32'(pcv[0]),   0);
        check("j_ir_kept", 32'(ir[0]),    32'h2010);
        q0.push_back({7'h7F, 16'h2001});
        q0.push_back({7'h00, 16'h3000});
        ready[0] = 1'b1;
        drain0();
        ready[0] = 1'b0;

        // Asynchronous reset while a ROM read is in flight
        tick(1);
        #2 rst_n[0] = 1'b0;
        #1;
        check("r_valid",  32'(valid[0]),  0);
        check("r_rd",     32'(rd[0]),     0);
        check("r_addr",   32'(addr[0]),   0);
        check("r_ir",     32'(ir[0]),     0);
        check("r_pc",     32'(pcv[0]),    0);
        check("r_halted", 32'(halted[0]), 0);
        tick(2);
        rst_n[0] = 1'b1;
        q0.push_back({7'h00, 16'h3000});
        ready[0] = 1'b1;
        drain0();
        ready[0] = 1'b0;

        // Latency 3: jump during WAIT discards the in-flight word
        check("c_rst_valid", 32'(valid[1]), 0);
        ready[1] = 1'b1;
        q1.push_back({7'h40, 16'h4ABC});
        rst_n[1] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            check($sformatf("c_valid@%0d", t), 32'(valid[1]), 32'(t == 7));
            check($sformatf("c_rd@%0d", t),    32'(rd[1]),    32'(t == 1 || t == 3 || t == 8));
            if (t == 3) check("c_addr_jump", 32'(addr[1]), 32'h40);
            if (t == 8) check("c_addr_next", 32'(addr[1]), 32'h41);
            if (t < 7) begin
                check($sformatf("c_pc@%0d", t), 32'(pcv[1]), 0);
                check($sformatf("c_ir@%0d", t), 32'(ir[1]),  0);
            end
            if (t == 2) begin
                jump[1]  = 1'b1;
                jaddr[1] = 7'h40;
            end
            if (t == 3) jump[1] = 1'b0;
        end
        ready[1] = 1'b0;
        check("c_drain", q1.size(), 0);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
